// File: rtl/frame_write_scheduler.sv
// frame_write_scheduler: moves GPU iteration-count batches into the frame
// buffer write port and swaps buffers on vsync once a frame is complete.
//
// Ports:
//   sys_clk_in          clock
//   rst_in              synchronous active-high reset
//   iters_valid_in      GPU batch valid
//   iters_in            batch of FMA_COUNT counts, first pixel in the MSBs
//   iters_ready_out     high in ACCEPT only
//   vsync_in            one-cycle vsync pulse (sys_clk_in domain)
//   fb_iters_valid_out  one-cycle write strobe, cycle after the handshake
//   fb_iters_out        registered batch data
//   fb_addr_write_out   base pixel address of the batch, held between strobes
//   swap_out            one-cycle buffer-swap pulse
//   frame_start_out     one-cycle pulse, GPU restarts at pixel 0
//   frame_count_out     completed swaps, wraps modulo 2^16
module frame_write_scheduler #(
    parameter int unsigned FMA_COUNT  = 2,
    parameter int unsigned ITERS_BITS = 4,
    parameter int unsigned WIDTH      = 320,
    parameter int unsigned HEIGHT     = 320
) (
    input  logic                                  sys_clk_in,
    input  logic                                  rst_in,
    input  logic                                  iters_valid_in,
    input  logic [FMA_COUNT*ITERS_BITS-1:0]       iters_in,
    output logic                                  iters_ready_out,
    input  logic                                  vsync_in,
    output logic                                  fb_iters_valid_out,
    output logic [FMA_COUNT*ITERS_BITS-1:0]       fb_iters_out,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]       fb_addr_write_out,
    output logic                                  swap_out,
    output logic                                  frame_start_out,
    output logic [15:0]                           frame_count_out
);

    localparam int unsigned PIX = WIDTH * HEIGHT;
    localparam int unsigned DW  = FMA_COUNT * ITERS_BITS;
    localparam int unsigned AW  = $clog2(PIX);
    // One extra bit so the pointer can reach PIX without wrapping.
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned CW  = $clog2(FMA_COUNT + 1);

    typedef enum logic [2:0] {
        START      = 3'd0,
        ACCEPT     = 3'd1,
        DRAIN      = 3'd2,
        WAIT_VSYNC = 3'd3,
        SWAP       = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q,   ptr_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [DW-1:0]   data_q,  data_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic            wr_q,    wr_d;
    logic [15:0]     fc_q,    fc_d;

    // State and datapath registers.
    always_ff @(posedge sys_clk_in) begin
        if (rst_in) begin
            state_q <= START;
            ptr_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            fc_q    <= fc_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        addr_d  = addr_q;
        wr_d    = 1'b0;
        fc_d    = fc_q;
        unique case (state_q)
            START: begin
                ptr_d   = '0;
                state_d = ACCEPT;
            end
            ACCEPT: begin
                if (iters_valid_in) begin
                    data_d  = iters_in;
                    addr_d  = AW'(ptr_q);
                    wr_d    = 1'b1;
                    ptr_d   = ptr_q + PW'(FMA_COUNT);
                    cnt_d   = CW'(FMA_COUNT);
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Holds the GPU off for FMA_COUNT cycles while the frame
                // buffer serialises the batch at the current address.
                if (cnt_q == CW'(1)) begin
                    state_d = (ptr_q == PW'(PIX)) ? WAIT_VSYNC : ACCEPT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WAIT_VSYNC: begin
                if (vsync_in) begin
                    fc_d    = fc_q + 16'd1;
                    state_d = SWAP;
                end
            end
            SWAP: begin
                state_d = START;
            end
            default: begin
                state_d = START;
            end
        endcase
    end

    // Pulse outputs decode the state; reset masks them so they stay quiet
    // while the FSM is parked in START.
    assign iters_ready_out    = (state_q == ACCEPT);
    assign swap_out           = (state_q == SWAP) && !rst_in;
    assign frame_start_out    = (state_q == START) && !rst_in;
    assign fb_iters_valid_out = wr_q;
    assign fb_iters_out       = data_q;
    assign fb_addr_write_out  = addr_q;
    assign frame_count_out    = fc_q;

endmodule

// File: tb/tb_frame_write_scheduler.sv
// Randomised scoreboard bench for frame_write_scheduler (4x4 frame, 2 counts
// per batch). A reference model predicts ready/swap/frame_start/frame_count
// each cycle and queues expected frame-buffer writes; a monitor pops them.
module tb_frame_write_scheduler;

    localparam int F   = 2;
    localparam int PIX = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [7:0]  data;
    logic        vsync;
    logic        ready;
    logic        fb_valid;
    logic [7:0]  fb_data;
    logic [3:0]  fb_addr;
    logic        swap;
    logic        fstart;
    logic [15:0] fcount;

    always #5 clk = ~clk;

    frame_write_scheduler #(
        .FMA_COUNT (2),
        .ITERS_BITS(4),
        .WIDTH     (4),
        .HEIGHT    (4)
    ) dut (
        .sys_clk_in        (clk),
        .rst_in            (rst),
        .iters_valid_in    (valid),
        .iters_in          (data),
        .iters_ready_out   (ready),
        .vsync_in          (vsync),
        .fb_iters_valid_out(fb_valid),
        .fb_iters_out      (fb_data),
        .fb_addr_write_out (fb_addr),
        .swap_out          (swap),
        .frame_start_out   (fstart),
        .frame_count_out   (fcount)
    );

    typedef struct {
        logic [7:0] data;
        int         addr;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: batches fill the frame two pixels at a time, each
    // acceptance is followed by F busy cycles, a full frame waits for vsync,
    // then one swap cycle and one frame-start cycle precede the next frame.
    int         m_ptr;
    int         m_busy;
    bit         m_done;
    int         m_seq;
    logic [15:0] m_fc;

    always @(negedge clk) begin
        int  seq_now;
        bit  exp_ready;
        if (rst) begin
            m_ptr  = 0;
            m_busy = 0;
            m_done = 0;
            m_seq  = 2;
            m_fc   = '0;
        end else begin
            seq_now   = m_seq;
            exp_ready = !m_done && (m_busy == 0) && (seq_now == 0);
            chk("ready",       32'(ready),  32'(exp_ready));
            chk("swap",        32'(swap),   32'(seq_now == 1));
            chk("frame_start", 32'(fstart), 32'(seq_now == 2));
            chk("frame_count", 32'(fcount), 32'(m_fc));
            if (seq_now == 1) begin
                m_seq = 2;
            end else if (seq_now == 2) begin
                m_seq  = 0;
                m_done = 0;
                m_ptr  = 0;
            end
            if (exp_ready && valid) begin
                sb.push_back('{data: data, addr: m_ptr, due: cyc + 1});
                m_ptr  = m_ptr + F;
                m_busy = F;
                if (m_ptr == PIX) m_done = 1;
            end else if (m_busy > 0) begin
                m_busy = m_busy - 1;
            end else if (m_done && seq_now == 0 && vsync) begin
                m_seq = 1;
                m_fc  = m_fc + 16'd1;
            end
        end
    end

    // Monitor: every strobe must match the oldest queued batch, one cycle
    // after its handshake; between strobes the address must hold.
    int last_addr = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            last_addr = 0;
        end else if (fb_valid) begin
            if (sb.size() == 0) begin
                chk("strobe_unexpected", 32'(fb_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("fb_data",        32'(fb_data), 32'(e.data));
                chk("fb_addr",        32'(fb_addr), 32'(e.addr));
                chk("strobe_latency", 32'(cyc),     32'(e.due));
                last_addr = e.addr;
            end
        end else begin
            chk("addr_hold", 32'(fb_addr), 32'(last_addr));
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                chk("strobe_missing", 32'(fb_valid), 32'd1);
                e = sb.pop_front();
            end
        end
    end

    bit hs_seen;
    bit fs_seen;

    task automatic step();
        @(negedge clk);
        hs_seen = valid && ready;
        fs_seen = fstart;
        @(posedge clk);
        #1;
        vsync = 1'b0;
    endtask

    // GPU holds data until accepted; with pv < 100 valid occasionally drops.
    task automatic run(input int n, input int pv, input int pvs);
        for (int i = 0; i < n; i++) begin
            step();
            if (hs_seen || !valid || (pv < 100 && $urandom_range(7) == 0)) begin
                valid = (int'($urandom_range(99)) < pv);
                data  = 8'($urandom);
            end
            vsync = (int'($urandom_range(99)) < pvs);
        end
    endtask

    initial begin
        int cnt;
        bit seen;
        bit reached;
        rst   = 1'b1;
        valid = 1'b0;
        data  = '0;
        vsync = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs",
                {ready, fb_valid, fb_data, fb_addr, swap, fstart, fcount}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single batch 0xA5 held high, then a full frame with valid held
        // high and no vsync: the frame must park with ready and swap low.
        valid = 1'b1;
        data  = 8'hA5;
        run(60, 100, 0);

        // Random traffic with vsync pulses landing in every state.
        run(1200, 80, 8);

        // Idle gap in ACCEPT: no strobe, pointer unchanged.
        valid = 1'b0;
        repeat (10) step();

        // Abort a frame after five batches of the current frame.
        cnt     = 0;
        seen    = 0;
        reached = 0;
        valid   = 1'b1;
        for (int i = 0; i < 400 && !reached; i++) begin
            step();
            if (fs_seen) begin
                cnt  = 0;
                seen = 1;
            end else if (hs_seen && seen) begin
                cnt++;
            end
            if (cnt == 5) begin
                reached = 1;
            end else begin
                valid = 1'b1;
                if (hs_seen) data = 8'($urandom);
                vsync = ($urandom_range(9) == 0);
            end
        end
        chk("midreset_reached", 32'(reached), 32'd1);
        rst   = 1'b1;
        valid = 1'b0;
        vsync = 1'b0;
        step();
        step();
        rst = 1'b0;

        run(600, 70, 8);

        valid = 1'b0;
        vsync = 1'b0;
        repeat (10) step();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
